fifo_stream_reader: RTL

Read-side drain stage that sits directly downstream of `fifo_memory`. It issues pops into the FIFO's `read_enable`/`empty` port, absorbs the one-cycle memory read latency, and presents the words on a valid/ready stream through a 3-entry output buffer. It sustains one word per cycle with no combinational path from `out_ready` to `fifo_read_enable`, so the downstream consumer can stall freely without losing or duplicating words.

---
 rtl/fifo_stream_reader.sv | 83 ++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain stage for fifo_memory: credit-limited pops, one-cycle read
// latency absorbed into a 3-entry circular buffer, valid/ready stream output.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  fifo_read_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            buf_level
);

  // Output handshake: a word moves on a rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [DATA_WIDTH-1:0] buf_d [3];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [2:0]            credit_used;
  logic                  capture;
  logic                  transfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    // Counting the in-flight word as occupied keeps capture from overflowing.
    credit_used      = {1'b0, occ_q} + {2'b00, inflight_q};
    fifo_read_enable = rstn && !fifo_empty && !flush && (credit_used < 3'd3);
    out_valid        = (occ_q != 2'd0);
    out_data         = buf_q[head_q];
    buf_level        = occ_q;
    transfer         = out_valid && out_ready;
    capture          = inflight_q && !flush;

    buf_d      = buf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = fifo_read_enable;

    if (capture) begin
      buf_d[tail_q] = fifo_read_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (transfer) begin
      head_d = ptr_inc(head_q);
    end
    occ_d = occ_q + {1'b0, capture} - {1'b0, transfer};

    if (flush) begin
      head_d = 2'd0;
      tail_d = 2'd0;
      occ_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
